// File: rtl/seq_multiplier.sv
// Iterative shift-add multiplier: WIDTH-bit operands, 2*WIDTH-bit product, one multiplier bit per cycle.
// Optional early termination when the remaining multiplier bits are zero: define MULT_EARLY_TERM_EN.
module seq_multiplier #(
    parameter int unsigned WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 is_signed,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    output logic                 busy,
    output logic                 ready,
    output logic [2*WIDTH-1:0]   result
);

    localparam int unsigned SW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [SW-1:0] LAST_STEP = SW'(WIDTH - 1);
    localparam logic [SW-1:0] STEP_ONE  = SW'(1);
    localparam logic [WIDTH-1:0]   ONE_W  = WIDTH'(1);
    localparam logic [2*WIDTH-1:0] ONE_2W = (2*WIDTH)'(1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t state;
    state_t state_nx;

    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] mcand_sh;
    logic [WIDTH-1:0]   mplr_sh;
    logic [SW-1:0]      step;
    logic               neg_flag;

    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic               last_step;
    logic               early_done;

    // Magnitudes; |-2^(WIDTH-1)| = 2^(WIDTH-1) still fits as an unsigned WIDTH-bit value.
    always_comb begin
        mag_a = multiplicand;
        mag_b = multiplier;
        if (is_signed && multiplicand[WIDTH-1]) begin
            mag_a = (~multiplicand) + ONE_W;
        end
        if (is_signed && multiplier[WIDTH-1]) begin
            mag_b = (~multiplier) + ONE_W;
        end
    end

    assign last_step = (step == LAST_STEP);

`ifdef MULT_EARLY_TERM_EN
    logic zero_q;

    // Zero detection is registered, so termination lands one cycle after the multiplier empties.
    assign early_done = zero_q;
`else
    assign early_done = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        busy     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nx = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (last_step || early_done) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                busy     = 1'b1;
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc      <= '0;
            mcand_sh <= '0;
            mplr_sh  <= '0;
            step     <= '0;
            neg_flag <= 1'b0;
            ready    <= 1'b0;
            result   <= '0;
`ifdef MULT_EARLY_TERM_EN
            zero_q   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        mcand_sh <= {{WIDTH{1'b0}}, mag_a};
                        mplr_sh  <= mag_b;
                        neg_flag <= is_signed & (multiplicand[WIDTH-1] ^ multiplier[WIDTH-1]);
                        acc      <= '0;
                        step     <= '0;
                        ready    <= 1'b0;
`ifdef MULT_EARLY_TERM_EN
                        zero_q   <= 1'b0;
`endif
                    end
                end
                RUN: begin
                    if (mplr_sh[0]) begin
                        acc <= acc + mcand_sh;
                    end
                    mcand_sh <= mcand_sh << 1;
                    mplr_sh  <= mplr_sh >> 1;
                    step     <= step + STEP_ONE;
`ifdef MULT_EARLY_TERM_EN
                    zero_q   <= (mplr_sh == '0);
`endif
                end
                DONE: begin
                    result <= neg_flag ? ((~acc) + ONE_2W) : acc;
                    ready  <= 1'b1;
                end
                default: begin
                    ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_multiplier.sv
// Self-checking bench for seq_multiplier: directed cases plus random operands against an arithmetic reference.
module tb_seq_multiplier;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        is_signed;
    logic [15:0] multiplicand;
    logic [15:0] multiplier;
    logic        busy;
    logic        ready;
    logic [31:0] result;

    int total;
    int bad;

    seq_multiplier #(.WIDTH(16)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .is_signed    (is_signed),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .busy         (busy),
        .ready        (ready),
        .result       (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_prod(input logic [15:0] a, input logic [15:0] b, input logic s);
        longint pa;
        longint pb;
        longint p;
        if (s) begin
            pa = longint'($signed(a));
            pb = longint'($signed(b));
        end else begin
            pa = longint'({48'd0, a});
            pb = longint'({48'd0, b});
        end
        p = pa * pb;
        return p[31:0];
    endfunction

    function automatic int ref_lat(input logic [15:0] b, input logic s);
`ifdef MULT_EARLY_TERM_EN
        logic [15:0] mag;
        int p;
        int l;
        mag = (s && b[15]) ? 16'(-b) : b;
        p = -1;
        for (int i = 0; i < 16; i++) begin
            if (mag[i]) p = i;
        end
        l = p + 4;
        if (l > 17) l = 17;
        return l;
`else
        return (b == 16'h0) ? 17 : 17;
`endif
    endfunction

    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic s, input int inject);
        logic [31:0] exp_r;
        int exp_l;
        int n;
        exp_r = ref_prod(a, b, s);
        exp_l = ref_lat(b, s);
        multiplicand = a;
        multiplier   = b;
        is_signed    = s;
        start        = 1'b1;
        @(posedge clk); #1;
        start        = 1'b0;
        multiplicand = 16'($urandom);
        multiplier   = 16'($urandom);
        is_signed    = 1'($urandom);
        check("ready_drop", {63'd0, ready}, 64'd0);
        check("busy_rise", {63'd0, busy}, 64'd1);
        n = 0;
        while (!ready && n < 40) begin
            if (n == inject) begin
                start        = 1'b1;
                multiplicand = 16'h0100;
            end
            @(posedge clk); #1;
            n++;
            start = 1'b0;
            if (!ready) check("busy_hold", {63'd0, busy}, 64'd1);
        end
        check("latency", 64'(n), 64'(exp_l));
        check("result", {32'd0, result}, {32'd0, exp_r});
        check("busy_fall", {63'd0, busy}, 64'd0);
    endtask

    initial begin
        int cnt;
        logic [15:0] ra;
        logic [15:0] rb;
        total        = 0;
        bad          = 0;
        rst_n        = 1'b0;
        start        = 1'b0;
        is_signed    = 1'b0;
        multiplicand = '0;
        multiplier   = '0;

        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("idle_ready", {63'd0, ready}, 64'd0);
            check("idle_busy", {63'd0, busy}, 64'd0);
            check("idle_result", {32'd0, result}, 64'd0);
        end

        run_op(16'hFFFF, 16'hFFFF, 1'b0, -1);
        check("ready_sticky", {63'd0, ready}, 64'd1);
        run_op(16'hFFFD, 16'h0007, 1'b1, -1);
        run_op(16'h8000, 16'h8000, 1'b1, -1);
        run_op(16'h8000, 16'h0001, 1'b1, -1);
        repeat (3) @(posedge clk);
        #1 check("hold_result", {32'd0, result}, 64'hFFFF8000);
        check("hold_ready", {63'd0, ready}, 64'd1);

        run_op(16'h0002, 16'h0003, 1'b0, 3);
        repeat (2) @(posedge clk);
        #1 check("ignored_start_idle", {63'd0, busy}, 64'd0);

        run_op(16'h1234, 16'h0000, 1'b0, -1);
        run_op(16'h1234, 16'h0005, 1'b0, -1);
        run_op(16'h0000, 16'h8000, 1'b1, -1);
        run_op(16'h7FFF, 16'h4000, 1'b1, -1);

        multiplicand = 16'h1234;
        multiplier   = 16'h5678;
        is_signed    = 1'b0;
        start        = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 1; i <= 7; i++) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("rst_ready", {63'd0, ready}, 64'd0);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_result", {32'd0, result}, 64'd0);
        rst_n = 1'b1;
        cnt = 0;
        for (int i = 0; i < 25; i++) begin
            @(posedge clk); #1;
            if (ready) cnt++;
        end
        check("no_ready_after_rst", 64'(cnt), 64'd0);

        for (int i = 0; i < 40; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom) >> $urandom_range(0, 16);
            run_op(ra, rb, 1'($urandom), -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
